// File: rtl/dsd_divider_mb.sv
// Iterative radix-2^BPC restoring integer divider with three signedness modes.
// Divide-by-zero and signed overflow bypass the iteration and go straight to FIX.
module dsd_divider_mb #(
    parameter int WID = 64,
    parameter int BPC = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld,
    input  logic           abort,
    input  logic [1:0]     mode,
    input  logic [WID-1:0] a,
    input  logic [WID-1:0] b,
    output logic [WID-1:0] qo,
    output logic [WID-1:0] ro,
    output logic           dvByZr,
    output logic           ovf,
    output logic           done,
    output logic           idle
);
    localparam int STEPS = WID / BPC;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [WID-1:0] q;
    logic [WID-1:0] r;
    logic [WID-1:0] bb;
    logic [CW-1:0]  cnt;
    logic           so;
    logic           sr;
    logic           dz;
    logic           of;

    logic           a_neg;
    logic           b_neg;
    logic [WID-1:0] a_mag;
    logic [WID-1:0] b_mag;
    logic           start_dz;
    logic           start_ovf;
    logic           start;
    logic [WID-1:0] min_val;
    logic [WID-1:0] q_step;
    logic [WID-1:0] r_step;
    logic [WID:0]   trial;

    assign min_val = {1'b1, {(WID-1){1'b0}}};
    assign start   = ld && !abort;

    always_comb begin
        a_neg     = ((mode == 2'b01) || (mode == 2'b10)) && a[WID-1];
        b_neg     = (mode == 2'b01) && b[WID-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        start_dz  = (b == '0);
        start_ovf = (mode == 2'b01) && (a == min_val) && (b == '1);
    end

    // BPC restoring steps per cycle; the trial remainder needs one extra bit
    always_comb begin
        q_step = q;
        r_step = r;
        trial  = '0;
        for (int i = 0; i < BPC; i++) begin
            trial  = {r_step, q_step[WID-1]};
            q_step = {q_step[WID-2:0], 1'b0};
            if (trial >= {1'b0, bb}) begin
                trial     = trial - {1'b0, bb};
                q_step[0] = 1'b1;
            end
            r_step = trial[WID-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (start_dz || start_ovf) ? FIX : DIV;
                end
            end
            DIV: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == CW'(1)) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = abort ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idle = (state == IDLE);
        done = (state == DONE);
    end

    // On divide-by-zero q keeps the raw dividend so FIX can return it as remainder
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q      <= '0;
            r      <= '0;
            bb     <= '0;
            cnt    <= '0;
            so     <= 1'b0;
            sr     <= 1'b0;
            dz     <= 1'b0;
            of     <= 1'b0;
            qo     <= '0;
            ro     <= '0;
            dvByZr <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        q   <= start_dz ? a : a_mag;
                        bb  <= b_mag;
                        r   <= '0;
                        cnt <= CW'(STEPS);
                        so  <= a_neg ^ b_neg;
                        sr  <= a_neg;
                        dz  <= start_dz;
                        of  <= start_ovf && !start_dz;
                    end
                end
                DIV: begin
                    if (!abort) begin
                        q   <= q_step;
                        r   <= r_step;
                        cnt <= cnt - CW'(1);
                    end
                end
                FIX: begin
                    if (!abort) begin
                        if (dz) begin
                            qo     <= '1;
                            ro     <= q;
                            dvByZr <= 1'b1;
                            ovf    <= 1'b0;
                        end else if (of) begin
                            qo     <= min_val;
                            ro     <= '0;
                            dvByZr <= 1'b0;
                            ovf    <= 1'b1;
                        end else begin
                            qo     <= so ? -q : q;
                            ro     <= sr ? -r : r;
                            dvByZr <= 1'b0;
                            ovf    <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
